// File: rtl/fls_pkg.sv
// Shared types for the Fibonacci-like sequence walkers: FSM state encoding and default data width.
package fls_pkg;
  localparam int unsigned FLS_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_HI,
    RUN,
    DONE
  } fls_state_e;
endpackage

// File: rtl/en_edge.sv
// Turns a raw level enable into a one-clk pulse on the clk after it rises.
// A level already high when reset releases stays ignored until it has been seen low once.
module en_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  output logic pulse
);
  logic lvl_q, lvl_d;
  logic armed_q, armed_d;
  logic pulse_q, pulse_d;

  always_comb begin
    lvl_d   = lvl;
    armed_d = armed_q | ~lvl;
    pulse_d = lvl & ~lvl_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q   <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/fls_rev.sv
// Walks a Fibonacci-like pair backward, one step per enable press, until no step is permitted.
// Optional FLS_REV_STEPCNT_EN adds a saturating 'steps' output counting steps since RUN entry.
module fls_rev
  import fls_pkg::*;
#(
  parameter int unsigned WIDTH = FLS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
`ifdef FLS_REV_STEPCNT_EN
  output logic [WIDTH-1:0] steps,
`endif
  output logic [WIDTH-1:0] f,
  output logic             done,
  output logic             loaded
);
  fls_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             ep;
  logic             permit;
  logic             step;

  en_edge u_en_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .lvl   (en),
    .pulse (ep)
  );

  // Guarding with hi>=lo means the subtraction below can never wrap.
  assign permit = (hi_q >= lo_q) && (lo_q != '0);
  assign step   = (state_q == RUN) && permit && ep;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (ep) begin
          hi_d    = d;
          lo_d    = '0;
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (ep) begin
          lo_d    = d;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!permit) begin
          state_d = DONE;
        end else if (ep) begin
          hi_d = lo_q;
          lo_d = hi_q - lo_q;
        end
      end
      DONE: begin
        if (ep) begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign f      = lo_q;
  assign done   = (state_q == DONE);
  assign loaded = (state_q == RUN) || (state_q == DONE);

`ifdef FLS_REV_STEPCNT_EN
  logic [WIDTH-1:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (state_q == IDLE) begin
      steps_d = '0;
    end else if (step && (steps_q != '1)) begin
      steps_d = steps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else begin
      steps_q <= steps_d;
    end
  end

  assign steps = steps_q;
`endif
endmodule

// File: tb/tb_fls_rev.sv
// Directed bench for fls_rev: hand-computed backward walks, boundary pairs, enable and reset corner cases.
module tb_fls_rev;
  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic         en;
  logic [W-1:0] f;
  logic         done;
  logic         loaded;
`ifdef FLS_REV_STEPCNT_EN
  logic [W-1:0] steps;
`endif

  int n_chk;
  int n_fail;

  fls_rev #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .en     (en),
`ifdef FLS_REV_STEPCNT_EN
    .steps  (steps),
`endif
    .f      (f),
    .done   (done),
    .loaded (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One press: en high for one clk, then sample one clk after the FSM has acted.
  task automatic press();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    @(negedge clk);
  endtask

  int exp_f[7] = '{8, 5, 3, 2, 1, 1, 0};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    en     = 1'b0;
    d      = '0;
    rst_n  = 1'b0;
    #12;
    chk("rst_f", f, 0);
    chk("rst_done", done, 0);
    chk("rst_loaded", loaded, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // 21,13 walked down to zero
    d = 7'd21;
    press();
    chk("ldhi_f", f, 0);
    chk("ldhi_loaded", loaded, 0);
    d = 7'd13;
    press();
    chk("ld_f", f, 13);
    chk("ld_loaded", loaded, 1);
    chk("ld_done", done, 0);
    d = 7'd99;
    repeat (3) @(negedge clk);
    chk("hold_f", f, 13);
    for (int i = 0; i < 7; i++) begin
      press();
      chk($sformatf("walk_f%0d", i), f, exp_f[i]);
    end
    @(negedge clk);
    chk("walk_done", done, 1);
    chk("walk_loaded", loaded, 1);
`ifdef FLS_REV_STEPCNT_EN
    chk("walk_steps", steps, 7);
`endif
    press();
    chk("ret_f", f, 0);
    chk("ret_done", done, 0);
    chk("ret_loaded", loaded, 0);
`ifdef FLS_REV_STEPCNT_EN
    chk("ret_steps", steps, 0);
`endif

    // 10,7 stops when hi<lo
    d = 7'd10; press();
    d = 7'd7;  press();
    chk("p2_ld_f", f, 7);
    press();
    chk("p2_f1", f, 3);
    press();
    chk("p2_f2", f, 4);
    @(negedge clk);
    chk("p2_done", done, 1);
    press();
    chk("p2_idle_f", f, 0);
    chk("p2_idle_done", done, 0);

    // 5,9 cannot step at all
    d = 7'd5; press();
    d = 7'd9; press();
    chk("p3_f", f, 9);
    @(negedge clk);
    chk("p3_done", done, 1);
    chk("p3_f_hold", f, 9);
    press();

    // 127,127 steps to (127,0) with no wrap
    d = 7'd127; press();
    d = 7'd127; press();
    chk("max_ld_f", f, 127);
    press();
    chk("max_f", f, 0);
    @(negedge clk);
    chk("max_done", done, 1);
    press();

    // en held high 20 clk in RUN gives one step
    d = 7'd34; press();
    d = 7'd21; press();
    chk("held_ld_f", f, 21);
    @(negedge clk) en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_f", f, 13);
    chk("held_done", done, 0);
`ifdef FLS_REV_STEPCNT_EN
    chk("held_steps", steps, 1);
`endif

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_f", f, 0);
    chk("arst_done", done, 0);
    chk("arst_loaded", loaded, 0);

    // en high through reset release must not yield a pulse
    en = 1'b1;
    d  = 7'd50;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    d = 7'd4; press();
    chk("noep_loaded", loaded, 0);
    d = 7'd3; press();
    chk("noep_f", f, 3);
    chk("noep_loaded2", loaded, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fls_rev.md
FLS_REV -- requirements
Module: fls_rev

Interface
REQ-001 WIDTH, 7, data width of operand input and term output.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
REQ-004 d  input  WIDTH  operand entry (unsigned), sampled on accepted enable pulse.
REQ-005 en  input  1  raw level enable (button); block SHALL act on its rising edge only.
REQ-006 f  output  WIDTH  current (earlier) term of the loaded pair.
REQ-007 done  output  1  high when no further backward step is permitted.
REQ-008 loaded  output  1  high once both terms of a pair are held.

Function
REQ-009 Block SHALL walk a Fibonacci-like sequence backward: from pair (hi=t[n+1], lo=t[n]) one step yields (hi=lo, lo=hi-lo).
REQ-010 Enable SHALL be reduced to a one-clk pulse (ep) on the clk after en rises; en held high SHALL give exactly one ep.
REQ-011 FSM states: IDLE, LOAD_HI, RUN, DONE; all transitions only on ep, except RUN->DONE per REQ-015.
REQ-012 IDLE + ep: hi<=d, lo<=0, state->LOAD_HI; f=0, loaded=0.
REQ-013 LOAD_HI + ep: lo<=d, state->RUN; loaded=1 from next clk; f=lo.
REQ-014 RUN + ep with step permitted (hi>=lo and lo!=0): (hi,lo)<=(lo,hi-lo); f updates 1 clk after ep.
REQ-015 RUN with step not permitted (hi<lo or lo==0): state->DONE on next clk without ep; done=1 combinationally from DONE.
REQ-016 DONE + ep: return to IDLE, hi,lo<=0, done=0, loaded=0.
REQ-017 Subtraction SHALL be unsigned WIDTH-bit; never performed when hi<lo (no wrap ever reaches f).
REQ-018 No ep: hi, lo, state SHALL hold.
REQ-019 d changes while no ep SHALL not affect state.

Reset
REQ-020 rst_n low: state=IDLE, hi=lo=0, f=0, done=0, loaded=0, edge-detect history=0, immediately (asynchronous).
REQ-021 rst_n mid-RUN SHALL abandon the pair; en held high through rst_n release SHALL not produce ep.

Configuration
REQ-022 Macro FLS_REV_STEPCNT_EN: when defined, extra output steps (WIDTH bits) counts backward steps taken since RUN entry, cleared in IDLE/reset, saturates at all-ones.
REQ-023 Macro undefined: no steps port, no counter logic; all other behaviour identical.

Structure
REQ-024 Shared package fls_pkg SHALL hold FSM state enum (IDLE, LOAD_HI, RUN, DONE) and default WIDTH constant.
REQ-025 Rising-edge pulse generator SHALL be a separate sub-module en_edge (clk, rst_n, level in, pulse out), reusable by the forward generator.

Verification
REQ-026 Load 21 then 13, then 7 pulses -> f: 13,8,5,3,2,1,1,0; done=1 after f=0; (steps=7 with FLS_REV_STEPCNT_EN).
REQ-027 Load 10 then 7, pulse twice -> f: 7,3,4; done=1 (hi=3<lo=4), further pulse -> IDLE, f=0.
REQ-028 Load 5 then 9 -> f=9, done=1 next clk, no step possible.
REQ-029 en held high 20 clk in RUN -> exactly one step.
REQ-030 Assert rst_n low mid-RUN (pair 34,21) asynchronously between edges -> f=0, done=0, loaded=0 before next posedge.
REQ-031 Max-width pair 127,127 -> step gives (127,0), f=0, done=1; no wrap.
